// File: rtl/bcd_button_counter.sv
// Two-digit BCD up/down/clear counter fed by three raw push-buttons.
// Optional auto-repeat on held up/down buttons: define BCD_AUTO_REPEAT_EN.
module bcd_button_counter #(
  parameter int DEBOUNCE     = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clr,
  output logic [7:0] value,
  output logic       changed
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int UP = 0;
  localparam int DN = 1;
  localparam int CL = 2;

  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [2:0]    deb_d;
  logic [2:0]    step;
  logic [CW-1:0] deb_cnt [3];
  logic [1:0]    rep;
  logic          up_step;
  logic          dn_step;
  logic [7:0]    next_value;
  logic          apply;

  assign raw = {btn_clr, btn_down, btn_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      step  <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      step  <= deb & ~deb_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CW'(DEBOUNCE - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef BCD_AUTO_REPEAT_EN
  logic [31:0] rep_cnt [2];

  // Counter loads on the press edge so the first repeat lands REPEAT_DELAY after the press step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep <= '0;
      for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep[i] <= 1'b0;
        if (!deb[i] || (deb[i] && !deb_d[i])) begin
          rep_cnt[i] <= 32'(REPEAT_DELAY - 1);
        end else if (rep_cnt[i] == '0) begin
          rep[i]     <= ~(deb[UP] & deb[DN]);
          rep_cnt[i] <= 32'(REPEAT_RATE - 1);
        end else begin
          rep_cnt[i] <= rep_cnt[i] - 1'b1;
        end
      end
    end
  end
`else
  localparam logic REP_CFG = (REPEAT_DELAY > 0) || (REPEAT_RATE > 0);
  assign rep = {2{REP_CFG & 1'b0}};
`endif

  assign up_step = step[UP] | rep[UP];
  assign dn_step = step[DN] | rep[DN];

  always_comb begin
    next_value = value;
    apply      = 1'b0;
    if (step[CL]) begin
      next_value = 8'h00;
      apply      = 1'b1;
    end else if (up_step && dn_step) begin
      apply = 1'b0;
    end else if (up_step) begin
      apply = 1'b1;
      if (value[3:0] == 4'd9) begin
        next_value[3:0] = 4'd0;
        next_value[7:4] = (value[7:4] == 4'd9) ? 4'd0 : value[7:4] + 4'd1;
      end else begin
        next_value[3:0] = value[3:0] + 4'd1;
      end
    end else if (dn_step) begin
      apply = 1'b1;
      if (value[3:0] == 4'd0) begin
        next_value[3:0] = 4'd9;
        next_value[7:4] = (value[7:4] == 4'd0) ? 4'd9 : value[7:4] - 4'd1;
      end else begin
        next_value[3:0] = value[3:0] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value   <= 8'h00;
      changed <= 1'b0;
    end else begin
      value   <= next_value;
      changed <= apply;
    end
  end

endmodule

// File: tb/tb_bcd_button_counter.sv
// Directed bench for bcd_button_counter with DEBOUNCE=4 (repeat 20/8).
module tb_bcd_button_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_clr = 1'b0;
  logic [7:0] value;
  logic       changed;

  int n_checks = 0;
  int n_errors = 0;
  int n_chg = 0;
  int exp_val = 0;
  int chg0;
  int lat;

  bcd_button_counter #(.DEBOUNCE(4), .REPEAT_DELAY(20), .REPEAT_RATE(8)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .value(value), .changed(changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (changed) n_chg++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int e);
    return 8'(((e / 10) << 4) | (e % 10));
  endfunction

  task automatic drive(input logic u, input logic d, input logic c);
    btn_up   = u;
    btn_down = d;
    btn_clr  = c;
  endtask

  task automatic press(input logic u, input logic d, input logic c, input int hold);
    @(negedge clk);
    drive(u, d, c);
    repeat (hold) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
  endtask

  // Counts edges from the first one that samples a freshly driven level until changed shows.
  task automatic measure_latency(output int k_seen);
    k_seen = -1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (changed && k_seen < 0) k_seen = k;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("reset_value", value, 8'h00);
    check("idle_no_changed", n_chg, 0);

    // first press with latency and pulse width
    chg0 = n_chg;
    @(negedge clk);
    btn_up = 1'b1;
    measure_latency(lat);
    check("up_latency", lat, 7);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    exp_val = 1;
    check("up_first", value, bcd(exp_val));
    check("changed_once", n_chg - chg0, 1);

    for (int i = 2; i <= 10; i++) begin
      press(1'b1, 1'b0, 1'b0, 10);
      exp_val = i;
      check($sformatf("up_%0d", i), value, bcd(exp_val));
    end
    check("chg_count_10", n_chg - chg0, 10);

    // three-cycle bounce then a clean hold: one increment only
    chg0 = n_chg;
    @(negedge clk);
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    btn_up = 1'b0;
    @(negedge clk);
    press(1'b1, 1'b0, 1'b0, 10);
    check("bounce_single", value, 8'h11);
    check("bounce_chg", n_chg - chg0, 1);

    // short glitch alone gives nothing
    @(negedge clk);
    btn_down = 1'b1;
    repeat (3) @(negedge clk);
    btn_down = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_ignored", value, 8'h11);

    press(1'b0, 1'b0, 1'b1, 10);
    check("clear", value, 8'h00);
    press(1'b0, 1'b1, 1'b0, 10);
    check("down_wrap", value, 8'h99);
    press(1'b1, 1'b0, 1'b0, 10);
    check("up_wrap", value, 8'h00);
    press(1'b0, 1'b1, 1'b0, 10);
    check("down_wrap2", value, 8'h99);
    for (int i = 0; i < 10; i++) press(1'b0, 1'b1, 1'b0, 10);
    check("down_borrow", value, 8'h89);

    chg0 = n_chg;
    press(1'b1, 1'b1, 1'b0, 10);
    check("up_down_same", value, 8'h89);
    check("up_down_no_chg", n_chg - chg0, 0);

    press(1'b0, 1'b0, 1'b1, 10);
    for (int i = 0; i < 42; i++) press(1'b1, 1'b0, 1'b0, 10);
    check("reach_42", value, 8'h42);
    chg0 = n_chg;
    press(1'b1, 1'b0, 1'b1, 10);
    check("clr_beats_up", value, 8'h00);
    press(1'b0, 1'b0, 1'b1, 10);
    check("clr_at_zero_chg", n_chg - chg0, 2);

    // reset while up is mid-debounce, released with up still held
    press(1'b1, 1'b0, 1'b0, 10);
    check("pre_rst", value, 8'h01);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_value", value, 8'h00);
    check("rst_changed", changed, 1'b0);
    rst = 1'b0;
    measure_latency(lat);
    check("rst_held_latency", lat, 7);
    check("rst_held_value", value, 8'h01);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);

    press(1'b0, 1'b0, 1'b1, 10);
    press(1'b1, 1'b0, 1'b0, 60);
`ifdef BCD_AUTO_REPEAT_EN
    check("long_hold", value, 8'h06);
`else
    check("long_hold", value, 8'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_button_counter.md
# bcd_button_counter

Two-digit BCD counter driven by three raw push-buttons (up, down, clear), with per-button synchronisation, debounce and rising-edge detection. `value[7:0]` carries the tens digit in [7:4] and the ones digit in [3:0]. It connects directly to the `SW[7:0]` input of the dual seven-segment display driver, so the board shows a decimal count from 00 to 99. The block runs on the same board clock as the display driver.

## Interface
- `DEBOUNCE`, default 50000: number of consecutive cycles a synchronised button level must differ from the debounced level before the debounced level is updated. Legal range is 2 to 2^20.
- `REPEAT_DELAY`, default 25000000: hold time in cycles before auto-repeat starts. Used only with `BCD_AUTO_REPEAT_EN`.
- `REPEAT_RATE`, default 10000000: cycles between repeated steps while held. Used only with `BCD_AUTO_REPEAT_EN`.
- `clk`, input, 1 bit: board clock. All state changes on its rising edge.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `btn_up`, input, 1 bit: raw, asynchronous, bouncing button. High means pressed. Increments the count.
- `btn_down`, input, 1 bit: raw button. Decrements the count.
- `btn_clr`, input, 1 bit: raw button. Forces the count to 00.
- `value`, output, 8 bits: {tens, ones}. Each digit is always in the range 0–9.
- `changed`, output, 1 bit: one-cycle pulse, high in the cycle in which `value` shows a newly updated count.

## Operation
- Per-button path:
  - A 2-flop synchroniser.
  - A debounce counter of width clog2(DEBOUNCE). It counts while the synchronised level differs from the debounced level and clears to 0 whenever they match. When it reaches DEBOUNCE-1 and the levels still differ, the debounced level takes the synchronised level and the counter clears.
  - A registered rising-edge detector on the debounced level, producing a one-cycle `step` pulse.
  - Release (falling debounced edge) produces no pulse.
- Counter update, evaluated each cycle in this priority order:
  1. `clr` pulse: set to 00. Any up/down pulse in the same cycle is ignored.
  2. `up` and `down` pulses in the same cycle: no change, and `changed` stays low.
  3. `up` pulse: BCD increment. The ones digit goes 9→0 with a carry into tens. 99 wraps to 00.
  4. `down` pulse: BCD decrement. The ones digit goes 0→9 with a borrow from tens. 00 wraps to 99.
- `changed` is asserted for any applied step, including a clear from 00 to 00 and both wrap cases.
- Digits are never outside 0–9. No binary-to-BCD conversion is used. Each digit is a separate 4-bit modulo-10 counter.
- Reset mid-bounce or mid-hold discards all partial state. After `rst` deasserts, a button that is still held is treated as a new press: the debounced level is 0, so the held level must be stable for DEBOUNCE cycles and then produces one step.

## Timing
- Reset values:
  - `value` = 8'h00
  - `changed` = 0
  - synchronisers, debounced levels, debounce counters and edge registers all 0
- Latency: a clean level change on a button pin, first sampled at clock edge N, appears at `value` after clock edge N+DEBOUNCE+3. `changed` is high for exactly that one cycle.
- Glitches shorter than DEBOUNCE cycles, measured after synchronisation, produce no step.
- Maximum step rate is one per press. Re-pressing requires a debounced release of at least DEBOUNCE cycles.
- `value` is a registered output with no combinational path from the inputs.

## Configuration
- `BCD_AUTO_REPEAT_EN` defined:
  - While the debounced up or down level stays high, the block issues an extra step pulse REPEAT_DELAY cycles after the initial press pulse, then one every REPEAT_RATE cycles until release.
  - Clear never repeats.
  - If both up and down are held, no repeat steps are issued.
  - The repeat counter resets on release and on `rst`.
- `BCD_AUTO_REPEAT_EN` not defined:
  - No repeat logic is instantiated. Exactly one step per press.
  - REPEAT_DELAY and REPEAT_RATE are ignored.

## Test plan
All scenarios use DEBOUNCE=4. Auto-repeat scenarios use REPEAT_DELAY=20 and REPEAT_RATE=8.
- Reset, then idle for 50 cycles -> `value`=8'h00, `changed` never high.
- Clean `btn_up` press held for 10 cycles, 9 times -> `value` steps 01..09. The 10th press gives 8'h10. `changed` pulses once per press, 7 edges after the first sampled high edge.
- 3 high cycles of `btn_up` bounce, then hold -> exactly one increment.
- At 8'h99, press up -> 8'h00. Press down -> 8'h99. Press down 10 times -> 8'h89.
- Debounced up and down pulses in the same cycle -> no change, no `changed`.
- `btn_clr` plus up in the same cycle at 8'h42 -> 8'h00.
- Assert `rst` while up is held mid-debounce, release `rst` with up still held -> `value`=8'h00, then 8'h01 after DEBOUNCE+3 edges.
- With `BCD_AUTO_REPEAT_EN`: hold up for 60 cycles from 8'h00 -> steps at the press, +20, +28, +36, +44, +52, giving 8'h06.
